// File: rtl/doc_uart_sender.sv
// Streams every document cell out as UART 8N1 frames, then pulses done.
// Optional row line breaks (CR LF) with DOC_UART_SENDER_LINE_BREAK_EN.
module doc_uart_sender #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 10,
  parameter int DOC_LEN  = 512,
  parameter int ROW_LEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              read_enable,
  output logic              done,
  output logic              busy,
  output logic              tx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CNT_W =
    (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(BIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST =
    ADDR_W'(DOC_LEN - 1);

  if (DOC_LEN < 1 || DOC_LEN > (1 << ADDR_W) ||
      ROW_LEN < 1 || BIT_CYCLES < 1) begin : g_cfg_err
    $error("doc_uart_sender: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP,
    DONE
`ifdef DOC_UART_SENDER_LINE_BREAK_EN
    ,
    EOL_CR,
    EOL_LF
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             send_prev;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

`ifdef DOC_UART_SENDER_LINE_BREAK_EN
  typedef enum logic [1:0] {
    K_CELL,
    K_CR,
    K_LF
  } kind_t;

  kind_t         kind;
  logic [ADDR_W:0] addr_inc;
  logic          eol;

  assign addr_inc = {1'b0, rd_addr} + (ADDR_W+1)'(1);
  assign eol = ((addr_inc % (ADDR_W+1)'(ROW_LEN)) == '0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      send_prev   <= 1'b0;
      rd_addr     <= '0;
      read_enable <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      tx          <= 1'b1;
`ifdef DOC_UART_SENDER_LINE_BREAK_EN
      kind        <= K_CELL;
`endif
    end else begin
      send_prev <= send_data;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send_data && !send_prev) begin
            rd_addr     <= '0;
            read_enable <= 1'b1;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          shift_reg <= rd_data;
          tx        <= 1'b0;
          cnt       <= '0;
          state     <= START;
`ifdef DOC_UART_SENDER_LINE_BREAK_EN
          kind      <= K_CELL;
`endif
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shift_reg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt       <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
`ifdef DOC_UART_SENDER_LINE_BREAK_EN
            if (kind == K_CELL && eol) begin
              state <= EOL_CR;
            end else if (kind == K_CR) begin
              state <= EOL_LF;
            end else if (rd_addr == ADDR_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= FETCH;
            end
`else
            if (rd_addr == ADDR_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= FETCH;
            end
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          read_enable <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
`ifdef DOC_UART_SENDER_LINE_BREAK_EN
        // EOL states stand in for FETCH with a fixed byte
        EOL_CR: begin
          shift_reg <= 8'h0D;
          tx        <= 1'b0;
          cnt       <= '0;
          kind      <= K_CR;
          state     <= START;
        end
        EOL_LF: begin
          shift_reg <= 8'h0A;
          tx        <= 1'b0;
          cnt       <= '0;
          kind      <= K_LF;
          state     <= START;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
